// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display arbiter and its decoders.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam int NIBBLE_W = 4;
  localparam int DIGITS   = 2;
  localparam int SEG_W    = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
  localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B   = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C   = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F   = 7'h71;

  // Blank overrides the nibble so a decoder never flashes stale digits.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble,
                                                  input logic blank);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return blank ? SEG_OFF : seg;
  endfunction

endpackage

// File: rtl/seg7_display_arbiter_if.sv
// Requester/display bundle of the 7-segment arbiter.
// The arbiter uses the slave view; a requester-side model uses the master view.
interface seg7_display_arbiter_if
  import seg7_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] data;
  logic [NUM_REQ-1:0]   ack;
  logic [NIBBLE_W-1:0]  upper_nibble;
  logic [NIBBLE_W-1:0]  lower_nibble;
  logic                 blank;
  logic                 busy;
  logic [IDX_W-1:0]     owner;

  modport master (
    output req, data,
    input  ack, upper_nibble, lower_nibble, blank, busy, owner
  );

  modport slave (
    input  req, data,
    output ack, upper_nibble, lower_nibble, blank, busy, owner
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Reusable by any arbiter that keeps its own pointer register.
module rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  // Scan from the farthest offset down so the nearest hit overwrites the others.
  always_comb begin : pick_search
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Round-robin sharing of a two-digit hex display among NUM_REQ requesters;
// each grant is latched and held for HOLD_CYCLES clocks.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter bit BLANK_WHEN_IDLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seg7_display_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    count, count_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [IDX_W-1:0]    owner, owner_n;
  logic [NIBBLE_W-1:0] upper, upper_n;
  logic [NIBBLE_W-1:0] lower, lower_n;
  logic [NUM_REQ-1:0]  ack, ack_n;
  logic                blank, blank_n;
  logic                busy, busy_n;

  logic                found;
  logic [IDX_W-1:0]    winner;
  logic                grant;
  logic [NIBBLE_W*DIGITS-1:0] value;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );

  assign value = bus.data[int'(winner)*8 +: 8];
  assign grant = found && ((state == ST_IDLE) || (count == '0));

  // Every output has a register image here so nothing combinational reaches the pins.
  always_comb begin
    state_n = state;
    count_n = count;
    ptr_n   = ptr;
    owner_n = owner;
    upper_n = upper;
    lower_n = lower;
    ack_n   = '0;
    blank_n = blank;

    if (grant) begin
      state_n       = ST_SHOW;
      count_n       = HOLD_RELOAD;
      ptr_n         = (winner == LAST_IDX) ? '0 : winner + 1'b1;
      owner_n       = winner;
      upper_n       = value[7:4];
      lower_n       = value[3:0];
      ack_n[winner] = 1'b1;
      blank_n       = 1'b0;
    end else if (state == ST_SHOW) begin
      if (count == '0) begin
        state_n = ST_IDLE;
        blank_n = BLANK_WHEN_IDLE;
      end else begin
        count_n = count - 1'b1;
      end
    end

    busy_n = (state_n == ST_SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      ptr   <= '0;
      owner <= '0;
      upper <= '0;
      lower <= '0;
      ack   <= '0;
      blank <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      upper <= upper_n;
      lower <= lower_n;
      ack   <= ack_n;
      blank <= blank_n;
      busy  <= busy_n;
    end
  end

  assign bus.ack          = ack;
  assign bus.upper_nibble = upper;
  assign bus.lower_nibble = lower;
  assign bus.blank        = blank;
  assign bus.busy         = busy;
  assign bus.owner        = owner;

endmodule
